// File: rtl/aes_pkg.sv
// Shared types and helpers for the AES byte-stream front end.
package aes_pkg;

    localparam int unsigned AES_BYTES = 16;
    localparam int unsigned BLK_W     = 128;
    localparam int unsigned BYTE_W    = 8;
    localparam int unsigned CNT_W     = 4;
    localparam int unsigned OFF_W     = 7;

    typedef enum logic [1:0] {
        LOAD  = 2'd0,
        START = 2'd1,
        WAIT  = 2'd2,
        DRAIN = 2'd3
    } state_e;

    // Bit offset of byte idx within a 128-bit block; shared by packing and unpacking.
    function automatic logic [OFF_W-1:0] byte_lane(input logic [CNT_W-1:0] idx,
                                                   input logic             msb_first);
        logic [CNT_W-1:0] lane;
        lane = msb_first ? ~idx : idx;
        return {lane, 3'b000};
    endfunction

endpackage

// File: rtl/aes_byte_stream_if.sv
// Byte-serial front end: packs key/plaintext bytes, launches the AES core,
// and streams the ciphertext back out a byte at a time.
module aes_byte_stream_if
    import aes_pkg::*;
#(
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [BYTE_W-1:0] in_data,
    input  logic             in_is_key,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [BYTE_W-1:0] out_data,
    output logic             out_last,
    output logic             core_start,
    output logic [BLK_W-1:0] core_plaintext,
    output logic [BLK_W-1:0] core_key,
    input  logic [BLK_W-1:0] core_ciphertext,
    input  logic             core_done,
    output logic             key_valid,
    output logic             busy
);

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(AES_BYTES - 1);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  key_cnt_q, key_cnt_d;
    logic [CNT_W-1:0]  pt_cnt_q, pt_cnt_d;
    logic [CNT_W-1:0]  out_cnt_q, out_cnt_d;
    logic [BLK_W-1:0]  key_q, key_d;
    logic [BLK_W-1:0]  pt_q, pt_d;
    logic [BLK_W-1:0]  ct_q, ct_d;
    logic              key_valid_q, key_valid_d;
    logic              core_start_q, core_start_d;
    logic              out_valid_q, out_valid_d;
    logic              out_last_q, out_last_d;
    logic [BYTE_W-1:0] out_data_q, out_data_d;
    logic              busy_q, busy_d;
    logic              key_acc;
    logic              pt_acc;

    // Next-state, datapath updates and registered-output precomputation.
    always_comb begin
        state_d      = state_q;
        key_cnt_d    = key_cnt_q;
        pt_cnt_d     = pt_cnt_q;
        out_cnt_d    = out_cnt_q;
        key_d        = key_q;
        pt_d         = pt_q;
        ct_d         = ct_q;
        key_valid_d  = key_valid_q;
        in_ready     = 1'b0;

        // Key bytes only enter on a plaintext block boundary; in START only
        // while the key is still incomplete.
        unique case (state_q)
            LOAD:    in_ready = ~in_is_key | (pt_cnt_q == '0);
            START:   in_ready = in_is_key & ~key_valid_q;
            default: in_ready = 1'b0;
        endcase

        key_acc = in_valid & in_ready & in_is_key;
        pt_acc  = in_valid & in_ready & ~in_is_key;

        if (key_acc) begin
            key_d[byte_lane(key_cnt_q, MSB_FIRST) +: BYTE_W] = in_data;
            key_cnt_d = key_cnt_q + CNT_W'(1);
            if (key_cnt_q == '0) begin
                key_valid_d = 1'b0;
            end
            if (key_cnt_q == LAST_IDX) begin
                key_valid_d = 1'b1;
            end
        end

        unique case (state_q)
            LOAD: begin
                if (pt_acc) begin
                    pt_d[byte_lane(pt_cnt_q, MSB_FIRST) +: BYTE_W] = in_data;
                    pt_cnt_d = pt_cnt_q + CNT_W'(1);
                    if (pt_cnt_q == LAST_IDX) begin
                        state_d = START;
                    end
                end
            end
            START: begin
                if (key_valid_q) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (core_done) begin
                    ct_d    = core_ciphertext;
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (out_ready) begin
                    out_cnt_d = out_cnt_q + CNT_W'(1);
                    if (out_cnt_q == LAST_IDX) begin
                        state_d = LOAD;
                    end
                end
            end
            default: state_d = LOAD;
        endcase

        // Start pulse covers exactly the one START cycle that has a valid key.
        core_start_d = (state_d == START) & key_valid_d;
        busy_d       = (state_d != LOAD);
        out_valid_d  = (state_d == DRAIN);
        out_last_d   = (state_d == DRAIN) & (out_cnt_d == LAST_IDX);
        out_data_d   = (state_d == DRAIN) ? ct_d[byte_lane(out_cnt_d, MSB_FIRST) +: BYTE_W]
                                          : '0;
    end

    // State and datapath registers with asynchronous abort.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= LOAD;
            key_cnt_q    <= '0;
            pt_cnt_q     <= '0;
            out_cnt_q    <= '0;
            key_q        <= '0;
            pt_q         <= '0;
            ct_q         <= '0;
            key_valid_q  <= 1'b0;
            core_start_q <= 1'b0;
            out_valid_q  <= 1'b0;
            out_last_q   <= 1'b0;
            out_data_q   <= '0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            key_cnt_q    <= key_cnt_d;
            pt_cnt_q     <= pt_cnt_d;
            out_cnt_q    <= out_cnt_d;
            key_q        <= key_d;
            pt_q         <= pt_d;
            ct_q         <= ct_d;
            key_valid_q  <= key_valid_d;
            core_start_q <= core_start_d;
            out_valid_q  <= out_valid_d;
            out_last_q   <= out_last_d;
            out_data_q   <= out_data_d;
            busy_q       <= busy_d;
        end
    end

    assign out_valid      = out_valid_q;
    assign out_data       = out_data_q;
    assign out_last       = out_last_q;
    assign core_start     = core_start_q;
    assign core_plaintext = pt_q;
    assign core_key       = key_q;
    assign key_valid      = key_valid_q;
    assign busy           = busy_q;

endmodule

// File: tb/tb_aes_byte_stream_if.sv
// Directed bench for aes_byte_stream_if with a behavioural stand-in for the AES core.
module tb_aes_byte_stream_if;

    localparam logic [127:0] FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] FIPS_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [7:0]   in_data;
    logic         in_is_key;
    logic         out_valid;
    logic         out_ready;
    logic [7:0]   out_data;
    logic         out_last;
    logic         core_start;
    logic [127:0] core_plaintext;
    logic [127:0] core_key;
    logic [127:0] core_ciphertext;
    logic         core_done;
    logic         key_valid;
    logic         busy;

    int n_vec = 0;
    int n_err = 0;
    int core_lat = 3;

    aes_byte_stream_if #(.MSB_FIRST(1'b1)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .in_data         (in_data),
        .in_is_key       (in_is_key),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_data        (out_data),
        .out_last        (out_last),
        .core_start      (core_start),
        .core_plaintext  (core_plaintext),
        .core_key        (core_key),
        .core_ciphertext (core_ciphertext),
        .core_done       (core_done),
        .key_valid       (key_valid),
        .busy            (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Core stand-in: real FIPS answer for the FIPS inputs, key^pt otherwise.
    // done is a level cleared at the start edge; ciphertext is garbage until done.
    logic [127:0] core_res;
    logic         core_run;
    int           core_cnt;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            core_done <= 1'b0;
            core_run  <= 1'b0;
            core_cnt  <= 0;
            core_res  <= '0;
        end else if (core_start) begin
            core_done <= 1'b0;
            core_run  <= 1'b1;
            core_cnt  <= core_lat;
            core_res  <= (core_key == FIPS_KEY && core_plaintext == FIPS_PT) ? FIPS_CT
                                                                              : core_key ^ core_plaintext;
        end else if (core_run) begin
            if (core_cnt == 0) begin
                core_done <= 1'b1;
                core_run  <= 1'b0;
            end else begin
                core_cnt <= core_cnt - 1;
            end
        end
    end

    assign core_ciphertext = core_done ? core_res : ~core_res;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] blk_byte(input logic [127:0] v, input int i);
        logic [127:0] s;
        s = v >> (8 * (15 - i));
        return s[7:0];
    endfunction

    task automatic chk_reset(input string where);
        chk({where, "_in_ready"},  128'(in_ready),       128'(1));
        chk({where, "_out_valid"}, 128'(out_valid),      128'(0));
        chk({where, "_out_last"},  128'(out_last),       128'(0));
        chk({where, "_out_data"},  128'(out_data),       128'(0));
        chk({where, "_core_start"},128'(core_start),     128'(0));
        chk({where, "_key_valid"}, 128'(key_valid),      128'(0));
        chk({where, "_busy"},      128'(busy),           128'(0));
        chk({where, "_core_key"},  core_key,             128'(0));
        chk({where, "_core_pt"},   core_plaintext,       128'(0));
    endtask

    // Offer one byte; returns 1ns after the accepting edge.
    task automatic send_byte(input logic is_key, input logic [7:0] d);
        int n;
        n = 0;
        @(negedge clk);
        in_valid  = 1'b1;
        in_is_key = is_key;
        in_data   = d;
        #1;
        while (!in_ready && n < 200) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (!in_ready) begin
            chk("send_timeout", 128'(in_ready), 128'(1));
        end else begin
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
    endtask

    task automatic send_block(input logic is_key, input logic [127:0] v);
        for (int i = 0; i < 16; i++) begin
            send_byte(is_key, blk_byte(v, i));
        end
    endtask

    // Collect nbytes ciphertext bytes; optional every-other-cycle backpressure.
    task automatic recv_block(input logic [127:0] exp, input bit bp, input int nbytes);
        int   i;
        int   cyc;
        bit   hold;
        bit   tog;
        logic [7:0] hd;
        logic       hl;
        i = 0; cyc = 0; hold = 0; tog = 0; hd = '0; hl = 0;
        while (i < nbytes && cyc < 500) begin
            @(negedge clk);
            out_ready = bp ? tog : 1'b1;
            tog = ~tog;
            #1;
            if (hold) begin
                chk($sformatf("hold_data%0d", i), 128'(out_data), 128'(hd));
                chk($sformatf("hold_last%0d", i), 128'(out_last), 128'(hl));
            end
            hold = 0;
            if (out_valid) begin
                chk("drain_in_ready", 128'(in_ready), 128'(0));
                if (out_ready) begin
                    chk($sformatf("ct_byte%0d", i), 128'(out_data), 128'(blk_byte(exp, i)));
                    chk($sformatf("last%0d", i), 128'(out_last), 128'(i == 15));
                    i++;
                end else begin
                    hold = 1;
                    hd   = out_data;
                    hl   = out_last;
                end
            end
            @(posedge clk);
            cyc++;
        end
        if (i < nbytes) chk("drain_timeout", 128'(i), 128'(nbytes));
        #1;
        out_ready = 1'b0;
    endtask

    logic [127:0] pt2, pt3, pt4, key2, pt5;

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_is_key = 1'b0;
        out_ready = 1'b0;
        pt2  = 128'ha0a1a2a3a4a5a6a7a8a9aaabacadaeaf;
        pt3  = 128'h0123456789abcdeffedcba9876543210;
        pt4  = 128'h3c3d3e3f404142434445464748494a4b;
        key2 = 128'hf0e1d2c3b4a5968778695a4b3c2d1e0f;
        pt5  = 128'h5555aaaa5555aaaa0f0f0f0ff0f0f0f0;

        #2;
        chk_reset("rst");
        @(negedge clk);
        rst_n = 1'b1;

        // FIPS-197 vector: key then plaintext.
        send_block(1'b1, FIPS_KEY);
        chk("fips_key_valid", 128'(key_valid), 128'(1));
        chk("fips_core_key", core_key, FIPS_KEY);
        send_block(1'b0, FIPS_PT);
        chk("fips_start", 128'(core_start), 128'(1));
        chk("fips_pt", core_plaintext, FIPS_PT);
        chk("fips_busy", 128'(busy), 128'(1));
        @(posedge clk); #1;
        chk("fips_start_one", 128'(core_start), 128'(0));
        chk("wait_in_ready", 128'(in_ready), 128'(0));
        recv_block(FIPS_CT, 1'b0, 16);
        chk("post_drain_in_ready", 128'(in_ready), 128'(1));
        chk("post_drain_busy", 128'(busy), 128'(0));
        chk("post_drain_out_valid", 128'(out_valid), 128'(0));

        // Key retention; previous done is still held high as a level.
        send_block(1'b0, pt2);
        chk("ret_start", 128'(core_start), 128'(1));
        chk("ret_key", core_key, FIPS_KEY);
        @(posedge clk); #1;
        chk("ret_wait_in_ready", 128'(in_ready), 128'(0));
        recv_block(FIPS_KEY ^ pt2, 1'b0, 16);

        // Key byte presented mid-plaintext is refused.
        for (int i = 0; i < 5; i++) send_byte(1'b0, blk_byte(pt3, i));
        @(negedge clk);
        in_valid  = 1'b1;
        in_is_key = 1'b1;
        in_data   = 8'hee;
        #1;
        chk("midpt_key_ready", 128'(in_ready), 128'(0));
        @(posedge clk); #1;
        in_valid  = 1'b0;
        chk("midpt_key_unchanged", core_key, FIPS_KEY);
        chk("midpt_key_valid", 128'(key_valid), 128'(1));
        for (int i = 5; i < 16; i++) send_byte(1'b0, blk_byte(pt3, i));
        chk("midpt_start", 128'(core_start), 128'(1));
        chk("midpt_pt", core_plaintext, pt3);
        recv_block(FIPS_KEY ^ pt3, 1'b0, 16);

        // Reset while waiting on the core.
        core_lat = 20;
        send_block(1'b0, pt4);
        repeat (3) @(posedge clk);
        #2;
        chk("pre_rst_busy", 128'(busy), 128'(1));
        rst_n = 1'b0;
        #1;
        chk_reset("rst_wait");
        @(negedge clk);
        rst_n    = 1'b1;
        core_lat = 3;

        // Plaintext before key, with drain backpressure.
        send_block(1'b0, FIPS_PT);
        chk("pbk_no_start", 128'(core_start), 128'(0));
        chk("pbk_busy", 128'(busy), 128'(1));
        in_is_key = 1'b0;
        #1;
        chk("pbk_pt_refused", 128'(in_ready), 128'(0));
        in_is_key = 1'b1;
        #1;
        chk("pbk_key_ready", 128'(in_ready), 128'(1));
        for (int i = 0; i < 15; i++) begin
            send_byte(1'b1, blk_byte(FIPS_KEY, i));
            chk($sformatf("pbk_hold%0d", i), 128'(core_start), 128'(0));
        end
        send_byte(1'b1, blk_byte(FIPS_KEY, 15));
        chk("pbk_key_valid", 128'(key_valid), 128'(1));
        chk("pbk_start", 128'(core_start), 128'(1));
        chk("pbk_key", core_key, FIPS_KEY);
        @(posedge clk); #1;
        chk("pbk_start_one", 128'(core_start), 128'(0));
        recv_block(FIPS_CT, 1'b1, 16);

        // Reset in DRAIN with byte 7 on the bus.
        send_block(1'b0, pt4);
        recv_block(FIPS_KEY ^ pt4, 1'b0, 7);
        chk("drain7_valid", 128'(out_valid), 128'(1));
        chk("drain7_data", 128'(out_data), 128'(blk_byte(FIPS_KEY ^ pt4, 7)));
        #1;
        rst_n = 1'b0;
        #1;
        chk_reset("rst_drain");
        @(negedge clk);
        rst_n = 1'b1;

        // Full reload after reset.
        send_block(1'b1, key2);
        chk("reload_key_valid", 128'(key_valid), 128'(1));
        send_block(1'b0, pt5);
        chk("reload_start", 128'(core_start), 128'(1));
        chk("reload_key", core_key, key2);
        recv_block(key2 ^ pt5, 1'b0, 16);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
